// File: rtl/bus_resolver.sv
// Per-lane arbiter that registers the winning internal driver onto a shared pad bus,
// with turnaround gaps on owner release, optional bus keeper and contention counting.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | lane released, no owner; next requester (lowest index) wins
// S_OWN  | lane driven by owner_q until that source drops its request
// S_GAP  | turnaround after release; gap_cnt counts the remaining cycles
module bus_resolver #(
    parameter int W    = 16,
    parameter int LANE = 8,
    parameter int N    = 4,
    parameter int TURN = 1,
    parameter int KEEP = 1,
    parameter int CW   = 8,
    localparam int L   = W / LANE,
    localparam int OW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic [N*W-1:0]    SRC_o,
    input  logic [N*L-1:0]    SRC_d,
    input  logic [W-1:0]      EXT_i,
    input  logic              CLR,
    output logic [W-1:0]      BUS_o,
    output logic [L-1:0]      BUS_d,
    output logic [W-1:0]      BUS_v,
    output logic [L*OW-1:0]   OWNER,
    output logic [L-1:0]      OWN_V,
    output logic [L-1:0]      CONTEND,
    output logic [CW-1:0]     CCOUNT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [3:0] TURN_C = 4'(TURN);

    logic [L-1:0] lane_cont;

    for (genvar j = 0; j < L; j++) begin : g_lane
        state_t            state, state_nx;
        logic [OW-1:0]     owner_q, owner_nx;
        logic [3:0]        gap_cnt, gap_nx;
        logic [N-1:0]      req;
        logic              low_v, multi, pick;
        logic [OW-1:0]     low_k;
        logic [LANE-1:0]   sel_data;
        logic [LANE-1:0]   bus_o_q;
        logic              bus_d_q, own_v_q;

        always_comb begin
            req   = '0;
            low_v = 1'b0;
            low_k = '0;
            multi = 1'b0;
            for (int k = 0; k < N; k++) begin
                req[k] = ~SRC_d[k*L + j];
            end
            for (int k = N - 1; k >= 0; k--) begin
                if (req[k]) begin
                    low_v = 1'b1;
                    low_k = OW'(k);
                end
            end
            for (int k = 0; k < N; k++) begin
                if (req[k] && low_v && (low_k != OW'(k))) begin
                    multi = 1'b1;
                end
            end
        end

        always_comb begin
            state_nx = state;
            owner_nx = owner_q;
            gap_nx   = gap_cnt;
            pick     = 1'b0;
            case (state)
                S_IDLE: pick = 1'b1;
                S_OWN: begin
                    if (!req[owner_q]) begin
                        if (TURN_C == 4'd0) begin
                            pick = 1'b1;
                        end else begin
                            state_nx = S_GAP;
                            gap_nx   = TURN_C;
                        end
                    end
                end
                S_GAP: begin
                    gap_nx = gap_cnt - 4'd1;
                    if (gap_cnt <= 4'd1) begin
                        pick = 1'b1;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
            // Arbitration point shared by IDLE, end of GAP and zero-turnaround release.
            if (pick) begin
                gap_nx = '0;
                if (low_v) begin
                    state_nx = S_OWN;
                    owner_nx = low_k;
                end else begin
                    state_nx = S_IDLE;
                end
            end
        end

        always_comb begin
            sel_data = '0;
            for (int k = 0; k < N; k++) begin
                if (owner_nx == OW'(k)) begin
                    sel_data = SRC_o[k*W + j*LANE +: LANE];
                end
            end
        end

        always_ff @(posedge MCLK or posedge RESET) begin
            if (RESET) begin
                state   <= S_IDLE;
                owner_q <= '0;
                gap_cnt <= '0;
                bus_o_q <= '0;
                bus_d_q <= 1'b1;
                own_v_q <= 1'b0;
            end else begin
                state   <= state_nx;
                gap_cnt <= gap_nx;
                if (state_nx == S_OWN) begin
                    owner_q <= owner_nx;
                    bus_o_q <= sel_data;
                    bus_d_q <= 1'b0;
                    own_v_q <= 1'b1;
                end else begin
                    bus_d_q <= 1'b1;
                    own_v_q <= 1'b0;
                    if (KEEP == 0) begin
                        bus_o_q <= '0;
                    end
                end
            end
        end

        assign lane_cont[j]               = multi;
        assign BUS_o[j*LANE +: LANE]      = bus_o_q;
        assign BUS_d[j]                   = bus_d_q;
        assign BUS_v[j*LANE +: LANE]      = bus_d_q ? EXT_i[j*LANE +: LANE] : bus_o_q;
        assign OWNER[j*OW +: OW]          = owner_q;
        assign OWN_V[j]                   = own_v_q;
    end

    // CLR wins over a same-cycle set or increment.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            CONTEND <= '0;
            CCOUNT  <= '0;
        end else if (CLR) begin
            CONTEND <= '0;
            CCOUNT  <= '0;
        end else begin
            CONTEND <= CONTEND | lane_cont;
            if ((|lane_cont) && (CCOUNT != {CW{1'b1}})) begin
                CCOUNT <= CCOUNT + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_resolver.sv
// Two bus_resolver instances (TURN=2/KEEP=1/CW=2 and TURN=0/KEEP=0/CW=8) on shared stimulus,
// compared every cycle against a per-lane ownership model kept in plain integers.
module tb_bus_resolver;

    logic        MCLK = 1'b0;
    logic        RESET = 1'b0;
    logic        CLR = 1'b0;
    logic [63:0] src_o = '0;
    logic [7:0]  src_d = 8'hFF;
    logic [15:0] ext_i = 16'hA55A;

    logic [15:0] a_bus_o, a_bus_v, b_bus_o, b_bus_v;
    logic [1:0]  a_bus_d, a_own_v, a_contend, b_bus_d, b_own_v, b_contend;
    logic [3:0]  a_owner, b_owner;
    logic [1:0]  a_ccount;
    logic [7:0]  b_ccount;

    int checks = 0;
    int errors = 0;

    int turn[2]   = '{2, 0};
    int keep[2]   = '{1, 0};
    int cmax[2]   = '{3, 255};

    // model: phase 0 = idle, 1 = owned by m_k, 2 = turnaround with m_gap cycles left
    int          m_ph[2][2];
    int          m_k[2][2];
    int          m_gap[2][2];
    logic [15:0] m_bo[2];
    logic [1:0]  m_bd[2];
    logic [3:0]  m_owner[2];
    logic [1:0]  m_ownv[2];
    logic [1:0]  m_cont[2];
    int          m_cnt[2];

    always #5 MCLK = ~MCLK;

    bus_resolver #(.W(16), .LANE(8), .N(4), .TURN(2), .KEEP(1), .CW(2)) u_a (
        .MCLK(MCLK), .RESET(RESET), .SRC_o(src_o), .SRC_d(src_d), .EXT_i(ext_i), .CLR(CLR),
        .BUS_o(a_bus_o), .BUS_d(a_bus_d), .BUS_v(a_bus_v), .OWNER(a_owner), .OWN_V(a_own_v),
        .CONTEND(a_contend), .CCOUNT(a_ccount)
    );

    bus_resolver #(.W(16), .LANE(8), .N(4), .TURN(0), .KEEP(0), .CW(8)) u_b (
        .MCLK(MCLK), .RESET(RESET), .SRC_o(src_o), .SRC_d(src_d), .EXT_i(ext_i), .CLR(CLR),
        .BUS_o(b_bus_o), .BUS_d(b_bus_d), .BUS_v(b_bus_v), .OWNER(b_owner), .OWN_V(b_own_v),
        .CONTEND(b_contend), .CCOUNT(b_ccount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                m_ph[i][j]  = 0;
                m_k[i][j]   = 0;
                m_gap[i][j] = 0;
            end
            m_bo[i]    = '0;
            m_bd[i]    = 2'b11;
            m_owner[i] = '0;
            m_ownv[i]  = '0;
            m_cont[i]  = '0;
            m_cnt[i]   = 0;
        end
    endtask

    task automatic model_edge(input int i);
        logic [1:0] cset;
        cset = '0;
        for (int j = 0; j < 2; j++) begin
            int n;
            int low;
            bit pick;
            n = 0;
            low = -1;
            pick = 0;
            for (int k = 3; k >= 0; k--) begin
                if (!src_d[k*2 + j]) begin
                    n++;
                    low = k;
                end
            end
            if (n >= 2) cset[j] = 1'b1;
            case (m_ph[i][j])
                0: pick = 1;
                1: begin
                    if (src_d[m_k[i][j]*2 + j]) begin
                        if (turn[i] == 0) pick = 1;
                        else begin
                            m_ph[i][j]  = 2;
                            m_gap[i][j] = turn[i];
                        end
                    end
                end
                default: begin
                    if (m_gap[i][j] == 1) pick = 1;
                    else m_gap[i][j] = m_gap[i][j] - 1;
                end
            endcase
            if (pick) begin
                m_gap[i][j] = 0;
                if (low >= 0) begin
                    m_ph[i][j] = 1;
                    m_k[i][j]  = low;
                end else begin
                    m_ph[i][j] = 0;
                end
            end
            if (m_ph[i][j] == 1) begin
                m_bd[i][j]             = 1'b0;
                m_bo[i][j*8 +: 8]      = src_o[m_k[i][j]*16 + j*8 +: 8];
                m_owner[i][j*2 +: 2]   = 2'(m_k[i][j]);
                m_ownv[i][j]           = 1'b1;
            end else begin
                m_bd[i][j]   = 1'b1;
                m_ownv[i][j] = 1'b0;
                if (keep[i] == 0) m_bo[i][j*8 +: 8] = 8'h00;
            end
        end
        if (CLR) begin
            m_cont[i] = '0;
            m_cnt[i]  = 0;
        end else begin
            m_cont[i] = m_cont[i] | cset;
            if (cset != 2'b00 && m_cnt[i] < cmax[i]) m_cnt[i]++;
        end
    endtask

    task automatic check_inst(input int i, input logic [15:0] bo, input logic [1:0] bd,
                              input logic [15:0] bv, input logic [3:0] ow, input logic [1:0] ov,
                              input logic [1:0] ct, input logic [7:0] cc);
        logic [15:0] exp_bv;
        for (int j = 0; j < 2; j++) begin
            exp_bv[j*8 +: 8] = m_bd[i][j] ? ext_i[j*8 +: 8] : m_bo[i][j*8 +: 8];
        end
        chk($sformatf("bus_o[%0d]", i), 32'(bo), 32'(m_bo[i]));
        chk($sformatf("bus_d[%0d]", i), 32'(bd), 32'(m_bd[i]));
        chk($sformatf("bus_v[%0d]", i), 32'(bv), 32'(exp_bv));
        chk($sformatf("owner[%0d]", i), 32'(ow), 32'(m_owner[i]));
        chk($sformatf("own_v[%0d]", i), 32'(ov), 32'(m_ownv[i]));
        chk($sformatf("contend[%0d]", i), 32'(ct), 32'(m_cont[i]));
        chk($sformatf("ccount[%0d]", i), 32'(cc), 32'(m_cnt[i]));
    endtask

    task automatic check_all();
        check_inst(0, a_bus_o, a_bus_d, a_bus_v, a_owner, a_own_v, a_contend, {6'd0, a_ccount});
        check_inst(1, b_bus_o, b_bus_d, b_bus_v, b_owner, b_own_v, b_contend, b_ccount);
    endtask

    task automatic step();
        @(posedge MCLK);
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        #1;
        model_reset();
        check_all();
        RESET = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int s = 0; s < n; s++) step();
    endtask

    initial begin
        #2;
        do_reset();
        chk("rst_bus_d", 32'(a_bus_d), 32'h3);
        chk("rst_bus_o", 32'(a_bus_o), 32'h0);
        chk("rst_bus_v", 32'(b_bus_v), 32'hA55A);

        // source 2 owns both lanes for 3 cycles, then releases
        src_o[32 +: 16] = 16'h1234;
        src_d = 8'hCF;
        step();
        chk("own2_bus_d", 32'(a_bus_d), 32'h0);
        chk("own2_bus_o", 32'(a_bus_o), 32'h1234);
        chk("own2_owner", 32'(a_owner), 32'hA);
        steps(2);
        src_d = 8'hFF;
        step();
        chk("rel_bus_d", 32'(a_bus_d), 32'h3);
        chk("rel_keep", 32'(a_bus_o), 32'h1234);
        steps(3);

        // source 1 owns, source 0 joins without preempting, source 1 releases
        src_o[0 +: 16]  = 16'hC0DE;
        src_o[16 +: 16] = 16'hBEEF;
        src_d = 8'hF3;
        steps(2);
        src_d = 8'hF0;
        steps(3);
        chk("nopreempt_owner", 32'(a_owner), 32'h5);
        chk("contend_set", 32'(a_contend), 32'h3);
        chk("ccount_3", 32'(a_ccount), 32'h3);
        src_d = 8'hFC;
        step();
        chk("gap1_bus_d", 32'(a_bus_d), 32'h3);
        chk("turn0_owner", 32'(b_owner), 32'h0);
        step();
        chk("gap2_bus_d", 32'(a_bus_d), 32'h3);
        step();
        chk("after_gap_owner", 32'(a_owner), 32'h0);
        chk("after_gap_bus_d", 32'(a_bus_d), 32'h0);
        src_d = 8'hFF;
        steps(3);

        // zero-turnaround handover 3 -> 1
        src_o[48 +: 16] = 16'h3333;
        src_d = 8'h3F;
        step();
        src_d = 8'hF3;
        step();
        chk("handover_owner", 32'(b_owner), 32'h5);
        chk("handover_bus_d", 32'(b_bus_d), 32'h0);
        src_d = 8'hFF;
        steps(3);

        // split lanes with CLR in the same cycle
        src_o[0 +: 16]  = 16'h00EE;
        src_o[48 +: 16] = 16'h7700;
        src_d = 8'h7E;
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        chk("split_bus_o", 32'(b_bus_o), 32'h77EE);
        chk("split_bus_d", 32'(a_bus_d), 32'h0);
        chk("split_contend", 32'(b_contend), 32'h0);

        // sustained contention: saturation, then CLR while it persists
        src_d = 8'h00;
        steps(6);
        chk("sat_ccount", 32'(a_ccount), 32'h3);
        chk("nosat_ccount", 32'(b_ccount), 32'h6);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        chk("clr_ccount", 32'(a_ccount), 32'h0);
        chk("clr_contend", 32'(a_contend), 32'h0);

        // reset while instance A is in its turnaround gap
        src_d = 8'hFF;
        step();
        do_reset();
        chk("midgap_bus_d", 32'(a_bus_d), 32'h3);

        // random traffic: requests held for several cycles, data and pad input churning
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(4) == 0) src_d[b] = ~src_d[b];
            end
            src_o = {$urandom, $urandom};
            ext_i = 16'($urandom);
            CLR   = ($urandom_range(15) == 0);
            step();
            if ($urandom_range(99) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
